// File: rtl/lcd_shadow_refresher.sv
// Avalon-MM master that repaints a 16x2 character LCD from a 32-byte shadow buffer.
// Hides slave init time and waitrequest handshakes from the host write port.
module lcd_shadow_refresher #(
   parameter int INIT_CYCLES = 1000000,
   parameter int GAP_CYCLES  = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       host_we,
   input  logic [4:0] host_addr,
   input  logic [7:0] host_wdata,
   input  logic       refresh_req,
   output logic       busy,
   output logic       refresh_done,
   output logic       m_address,
   output logic       m_chipselect,
   output logic       m_write,
   output logic       m_read,
   output logic [7:0] m_writedata,
   input  logic       m_waitrequest
);

   localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
   localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES - 1);

   localparam logic [2:0] S_INIT_WAIT = 3'd0;
   localparam logic [2:0] S_IDLE      = 3'd1;
   localparam logic [2:0] S_ISSUE     = 3'd2;
   localparam logic [2:0] S_GAP       = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   logic [2:0]     r_state;
   logic [ICW-1:0] r_init_cnt;
   logic [GCW-1:0] r_gap_cnt;
   logic [5:0]     r_step;
   logic           r_dirty;
   logic [7:0]     r_shadow [32];
   logic           r_addr;
   logic [7:0]     r_wdata;

   logic       w_host_evt;
   logic [5:0] w_load_step;
   logic [4:0] w_idx;
   logic       w_load_addr;
   logic [7:0] w_load_data;

   assign w_host_evt = host_we | refresh_req;

   // Address/data for the step about to enter ISSUE; latched so that later
   // host writes cannot disturb an access the slave has not yet accepted.
   always_comb begin
      w_load_step = (r_state == S_GAP) ? r_step + 6'd1 : '0;
      w_idx       = (w_load_step <= 6'd16) ? 5'(w_load_step - 6'd1) : 5'(w_load_step - 6'd2);
      w_load_addr = 1'b1;
      w_load_data = r_shadow[w_idx];
      if (w_load_step == 6'd0) begin
         w_load_addr = 1'b0;
         w_load_data = 8'h80;
      end else if (w_load_step == 6'd17) begin
         w_load_addr = 1'b0;
         w_load_data = 8'hC0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 32; i++) r_shadow[i] <= 8'h20;
      end else if (host_we) begin
         r_shadow[host_addr] <= host_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_INIT_WAIT;
         r_init_cnt <= '0;
         r_gap_cnt  <= '0;
         r_step     <= '0;
         r_dirty    <= 1'b1;
         r_addr     <= 1'b0;
         r_wdata    <= '0;
      end else begin
         r_dirty <= r_dirty | w_host_evt;
         case (r_state)
            S_INIT_WAIT: begin
               if (r_init_cnt == INIT_LAST) r_state <= S_IDLE;
               else                         r_init_cnt <= r_init_cnt + 1'b1;
            end
            S_IDLE: begin
               if (r_dirty) begin
                  r_state <= S_ISSUE;
                  r_step  <= '0;
                  r_dirty <= w_host_evt;
                  r_addr  <= w_load_addr;
                  r_wdata <= w_load_data;
               end
            end
            S_ISSUE: begin
               if (!m_waitrequest) begin
                  r_gap_cnt <= '0;
                  r_state   <= (r_step == 6'd33) ? S_DONE : S_GAP;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= S_ISSUE;
                  r_step  <= w_load_step;
                  r_addr  <= w_load_addr;
                  r_wdata <= w_load_data;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign refresh_done = (r_state == S_DONE);
   assign m_chipselect = (r_state == S_ISSUE);
   assign m_write      = m_chipselect;
   assign m_read       = 1'b0;
   assign m_address    = r_addr;
   assign m_writedata  = r_wdata;

endmodule

// File: tb/tb_lcd_shadow_refresher.sv
// Directed bench for lcd_shadow_refresher with a behavioural LCD slave that can
// stall each access for a programmable number of cycles.
module tb_lcd_shadow_refresher;

   localparam int INIT = 100;
   localparam int GAP  = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       host_we = 1'b0;
   logic [4:0] host_addr = '0;
   logic [7:0] host_wdata = '0;
   logic       refresh_req = 1'b0;
   logic       busy, refresh_done, m_address, m_chipselect, m_write, m_read;
   logic [7:0] m_writedata;
   logic       m_waitrequest = 1'b0;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   lcd_shadow_refresher #(.INIT_CYCLES(INIT), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .refresh_req(refresh_req), .busy(busy),
      .refresh_done(refresh_done), .m_address(m_address), .m_chipselect(m_chipselect),
      .m_write(m_write), .m_read(m_read), .m_writedata(m_writedata),
      .m_waitrequest(m_waitrequest)
   );

   always #5 clk = ~clk;

   // Slave model and access log
   int         wait_n = 0;
   int         wcnt = 0;
   int         low_cnt = 1000;
   int         done_cnt = 0;
   int         stab_err = 0;
   int         gap_err = 0;
   bit         in_acc = 0;
   logic [8:0] held;
   logic [8:0] acc_q[$];
   logic [7:0] exp_sh [32];

   always @(negedge clk) begin
      if (!reset_n) begin
         in_acc = 0; low_cnt = 1000; wcnt = 0; m_waitrequest = 1'b0;
      end else if (m_chipselect) begin
         if (!in_acc) begin
            in_acc = 1; held = {m_address, m_writedata}; wcnt = 0;
            if (low_cnt < GAP) gap_err++;
         end else if ({m_address, m_writedata} !== held) begin
            stab_err++;
         end
         low_cnt = 0;
         if (wcnt < wait_n) begin
            m_waitrequest = 1'b1; wcnt++;
         end else begin
            m_waitrequest = 1'b0; acc_q.push_back(held); in_acc = 0;
         end
      end else begin
         m_waitrequest = 1'b0; low_cnt++;
      end
      if (reset_n && refresh_done) done_cnt++;
   end

   function automatic logic [8:0] exp_acc(input logic [7:0] sh [32], input int s);
      if (s == 0)  return {1'b0, 8'h80};
      if (s == 17) return {1'b0, 8'hC0};
      if (s <= 16) return {1'b1, sh[s-1]};
      return {1'b1, sh[s-2]};
   endfunction

   task automatic host_write(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      host_we = 1'b1; host_addr = a; host_wdata = d;
      exp_sh[a] = d;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   task automatic pulse_req();
      @(negedge clk); refresh_req = 1'b1;
      @(negedge clk); refresh_req = 1'b0;
   endtask

   task automatic clear_log();
      acc_q.delete(); done_cnt = 0; stab_err = 0; gap_err = 0;
   endtask

   task automatic wait_done(input int n, input int budget, output bit to);
      int c = 0;
      to = 0;
      while (!(done_cnt >= n && !busy)) begin
         @(negedge clk);
         c++;
         if (c > budget) begin to = 1; break; end
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic start_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 32; i++) exp_sh[i] = 8'h20;
   endtask

   task automatic test_reset();
      int first = -1;
      logic [8:0] first_acc = '0;
      logic busy_init = 1'b0;
      bit to;
      wait_n = 0;
      start_reset();
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({busy, refresh_done, m_chipselect, m_write, m_read, m_address, m_writedata} !== 14'b10000_0_00000000)
         $display("FAIL reset_outputs got %b exp %b",
                  {busy, refresh_done, m_chipselect, m_write, m_read, m_address, m_writedata}, 14'b10000_0_00000000);
      else pass_cnt++;
      clear_log();
      reset_n = 1'b1;
      for (int c = 0; c < 150; c++) begin
         @(posedge clk); #1;
         if (m_chipselect && first < 0) begin first = c; first_acc = {m_address, m_writedata}; end
         if (c == 50) busy_init = busy;
      end
      chk_cnt++;
      if (first !== 100) $display("FAIL init_first_cs got %0d exp 100", first); else pass_cnt++;
      chk_cnt++;
      if (first_acc !== 9'h080) $display("FAIL init_first_acc got %h exp 080", first_acc); else pass_cnt++;
      chk_cnt++;
      if (busy_init !== 1'b1) $display("FAIL init_busy got %b exp 1", busy_init); else pass_cnt++;
      wait_done(1, 500, to);
      chk_cnt++;
      if (to) $display("FAIL init_pass_timeout got timeout exp done"); else pass_cnt++;
      chk_cnt++;
      if (acc_q.size() !== 34) $display("FAIL init_count got %0d exp 34", acc_q.size()); else pass_cnt++;
      for (int i = 0; i < 34; i++) begin
         chk_cnt++;
         if (acc_q[i] !== exp_acc(exp_sh, i))
            $display("FAIL init_acc[%0d] got %h exp %h", i, acc_q[i], exp_acc(exp_sh, i));
         else pass_cnt++;
      end
      chk_cnt++;
      if (done_cnt !== 1) $display("FAIL init_done_cnt got %0d exp 1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_hello();
      logic [7:0] h [5];
      logic [7:0] w [5];
      bit seen = 0;
      bit to;
      h = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      w = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
      start_reset();
      @(negedge clk);
      clear_log();
      reset_n = 1'b1;
      // Writes land during INIT_WAIT so exactly one pass follows.
      for (int i = 0; i < 5; i++) host_write(5'(i), h[i]);
      for (int i = 0; i < 5; i++) host_write(5'(16 + i), w[i]);
      for (int c = 0; c < 500 && !seen; c++) begin
         @(posedge clk); #1;
         if (refresh_done) seen = 1;
      end
      chk_cnt++;
      if (!seen || busy !== 1'b1) $display("FAIL done_busy got seen=%0d busy=%b exp seen=1 busy=1", seen, busy);
      else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++;
      if ({refresh_done, busy} !== 2'b00) $display("FAIL done_fall got %b exp 00", {refresh_done, busy});
      else pass_cnt++;
      wait_done(1, 100, to);
      chk_cnt++;
      if (acc_q.size() !== 34 || done_cnt !== 1)
         $display("FAIL hello_count got acc=%0d done=%0d exp acc=34 done=1", acc_q.size(), done_cnt);
      else pass_cnt++;
      for (int i = 0; i < 34; i++) begin
         chk_cnt++;
         if (acc_q[i] !== exp_acc(exp_sh, i))
            $display("FAIL hello_acc[%0d] got %h exp %h", i, acc_q[i], exp_acc(exp_sh, i));
         else pass_cnt++;
      end
   endtask

   task automatic test_waitrequest();
      bit to;
      wait_n = 7;
      clear_log();
      pulse_req();
      wait_done(1, 34 * 11 + 100, to);
      chk_cnt++;
      if (to || done_cnt !== 1 || acc_q.size() !== 34)
         $display("FAIL wait_pass got to=%0d done=%0d acc=%0d exp to=0 done=1 acc=34", to, done_cnt, acc_q.size());
      else pass_cnt++;
      for (int i = 0; i < 34; i++) begin
         chk_cnt++;
         if (acc_q[i] !== exp_acc(exp_sh, i))
            $display("FAIL wait_acc[%0d] got %h exp %h", i, acc_q[i], exp_acc(exp_sh, i));
         else pass_cnt++;
      end
      chk_cnt++;
      if (stab_err !== 0) $display("FAIL wait_stable got %0d exp 0", stab_err); else pass_cnt++;
      chk_cnt++;
      if (gap_err !== 0) $display("FAIL wait_gap got %0d exp 0", gap_err); else pass_cnt++;
   endtask

   task automatic test_midpass_write();
      logic [7:0] old_sh [32];
      bit hit = 0;
      bit to;
      wait_n = 3;
      clear_log();
      old_sh = exp_sh;
      pulse_req();
      for (int c = 0; c < 400 && !hit; c++) begin
         @(posedge clk); #1;
         if (acc_q.size() == 10 && m_chipselect) hit = 1;
      end
      chk_cnt++;
      if (!hit) $display("FAIL mid_reach_step10 got timeout exp step10"); else pass_cnt++;
      host_write(5'd3, 8'h41);
      wait_done(2, 800, to);
      chk_cnt++;
      if (to || done_cnt !== 2 || acc_q.size() !== 68)
         $display("FAIL mid_count got to=%0d done=%0d acc=%0d exp to=0 done=2 acc=68", to, done_cnt, acc_q.size());
      else pass_cnt++;
      for (int i = 0; i < 34; i++) begin
         chk_cnt++;
         if (acc_q[i] !== exp_acc(old_sh, i))
            $display("FAIL mid_pass1[%0d] got %h exp %h", i, acc_q[i], exp_acc(old_sh, i));
         else pass_cnt++;
         chk_cnt++;
         if (acc_q[34+i] !== exp_acc(exp_sh, i))
            $display("FAIL mid_pass2[%0d] got %h exp %h", i, acc_q[34+i], exp_acc(exp_sh, i));
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      wait_n = 0;
      clear_log();
      // Second request cycle coincides with the IDLE->ISSUE start.
      @(negedge clk); refresh_req = 1'b1;
      @(negedge clk);
      @(negedge clk); refresh_req = 1'b0;
      wait_done(2, 500, to);
      chk_cnt++;
      if (to || done_cnt !== 2 || acc_q.size() !== 68)
         $display("FAIL b2b_count got to=%0d done=%0d acc=%0d exp to=0 done=2 acc=68", to, done_cnt, acc_q.size());
      else pass_cnt++;
      for (int i = 0; i < 68; i++) begin
         chk_cnt++;
         if (acc_q[i] !== exp_acc(exp_sh, i % 34))
            $display("FAIL b2b_acc[%0d] got %h exp %h", i, acc_q[i], exp_acc(exp_sh, i % 34));
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_midpass();
      int first = -1;
      bit hit = 0;
      bit to;
      wait_n = 7;
      clear_log();
      pulse_req();
      for (int c = 0; c < 600 && !hit; c++) begin
         @(posedge clk); #1;
         if (acc_q.size() == 20 && m_chipselect && m_waitrequest) hit = 1;
      end
      chk_cnt++;
      if (!hit) $display("FAIL rst_reach_step20 got timeout exp step20"); else pass_cnt++;
      @(negedge clk); #2;
      start_reset();
      #1;
      chk_cnt++;
      if ({busy, refresh_done, m_chipselect, m_write, m_read, m_address, m_writedata} !== 14'b10000_0_00000000)
         $display("FAIL rst_async_outputs got %b exp %b",
                  {busy, refresh_done, m_chipselect, m_write, m_read, m_address, m_writedata}, 14'b10000_0_00000000);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      clear_log();
      reset_n = 1'b1;
      for (int c = 0; c < 120; c++) begin
         @(posedge clk); #1;
         if (m_chipselect && first < 0) first = c;
      end
      chk_cnt++;
      if (first !== 100) $display("FAIL rst_first_cs got %0d exp 100", first); else pass_cnt++;
      wait_done(1, 34 * 11 + 100, to);
      chk_cnt++;
      if (to || done_cnt !== 1 || acc_q.size() !== 34)
         $display("FAIL rst_pass got to=%0d done=%0d acc=%0d exp to=0 done=1 acc=34", to, done_cnt, acc_q.size());
      else pass_cnt++;
      for (int i = 0; i < 34; i++) begin
         chk_cnt++;
         if (acc_q[i] !== exp_acc(exp_sh, i))
            $display("FAIL rst_acc[%0d] got %h exp %h", i, acc_q[i], exp_acc(exp_sh, i));
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_hello();
      test_waitrequest();
      test_midpass_write();
      test_back_to_back();
      test_reset_midpass();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
